// File: rtl/mem_io_responder_pkg.sv
// Shared constants, IO decode types and the address decode helper
// for the memory/IO responder.
package mem_io_responder_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [17:0] IO_STAT = 18'h30004;
  localparam logic [1:0]  IO_PAGE = 2'b11;

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_DATA,
    SEL_STAT,
    SEL_NONE
  } io_sel_e;

  typedef struct packed {
    logic        wr;
    logic [17:0] a;
    logic [7:0]  dout;
  } bus_req_t;

  // STAT covers the four counter byte lanes 0x30004..0x30007.
  function automatic io_sel_e decode(input logic [17:0] a);
    io_sel_e s;
    s = SEL_NONE;
    if (a[17:16] != IO_PAGE)
      s = SEL_RAM;
    else if (a == IO_BASE)
      s = SEL_DATA;
    else if (a[17:2] == IO_STAT[17:2])
      s = SEL_STAT;
    return s;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: circular byte FIFO, depth SIZE = 2**WIDTH.
// Ports: i_push/i_din, i_pop/o_dout (head), o_full, o_empty, o_count.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int SIZE  = 8
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           i_push,
  input  logic [7:0]     i_din,
  input  logic           i_pop,
  output logic [7:0]     o_dout,
  output logic           o_full,
  output logic           o_empty,
  output logic [WIDTH:0] o_count
);

  logic [7:0]       r_mem [SIZE];
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [WIDTH:0]   r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == (WIDTH+1)'(SIZE));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_head];

  // A pop in the same cycle frees the slot a push needs when full.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk_in) begin
    if (w_push)
      r_mem[r_tail] <= i_din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + 1'b1;
      if (w_pop)
        r_head <= r_head + 1'b1;
      unique case (1'b1)
        (w_push & ~w_pop): r_count <= r_count + 1'b1;
        (w_pop & ~w_push): r_count <= r_count - 1'b1;
        default:           r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Slave end of the CPU byte bus: 128KB RAM plus an IO page with
// TX/RX FIFOs, a free-running cycle counter and a sticky stop flag.
// Ports: clk_in, rst_in (async low), cpu_a/cpu_wr/cpu_dout in,
// cpu_din (registered) out, io_buffer_full, rx_valid/rx_data/rx_ready,
// tx_valid/tx_data/tx_ready, prog_stop.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int FIFO_WIDTH     = 3,
  parameter int FIFO_SIZE      = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop
);

  localparam int RAM_SIZE = 2 ** RAM_ADDR_WIDTH;

  logic [7:0]  r_ram [RAM_SIZE];
  logic [7:0]  r_cpu_din;
  logic [31:0] r_cnt;
  logic [31:0] r_snap;
  logic        r_stop;

  bus_req_t                  w_req;
  io_sel_e                   w_sel;
  logic [RAM_ADDR_WIDTH-1:0] w_idx;
  logic [7:0]                w_rdata;
  logic                      w_snap_ld;
  logic                      w_ram_wr;
  logic                      w_stop_wr;
  logic                      w_rx_pop;
  logic                      w_rx_push;
  logic                      w_tx_push;
  logic                      w_tx_pop;
  logic [7:0]                w_tx_din;
  logic [7:0]                w_rx_dout;
  logic                      w_rx_full;
  logic                      w_rx_empty;
  logic [FIFO_WIDTH:0]       w_rx_count;
  logic                      w_tx_full;
  logic                      w_tx_empty;
  logic [FIFO_WIDTH:0]       w_tx_count;
  logic                      w_unused;

  assign w_req.wr   = cpu_wr;
  assign w_req.a    = cpu_a[17:0];
  assign w_req.dout = cpu_dout;

  assign w_sel = decode(w_req.a);
  assign w_idx = cpu_a[RAM_ADDR_WIDTH-1:0];

  assign w_ram_wr  = w_req.wr & (w_sel == SEL_RAM);
  assign w_stop_wr = w_req.wr & (w_sel == SEL_STAT)
                   & (w_req.a[1:0] == 2'b00);

  // Zero bytes written to the data port are dropped; the stop
  // write pushes a 0x00 marker so the host sees end of output.
  assign w_tx_push = (w_req.wr & (w_sel == SEL_DATA)
                   & (w_req.dout != 8'h00)) | w_stop_wr;
  assign w_tx_din  = w_stop_wr ? 8'h00 : w_req.dout;
  assign w_tx_pop  = tx_valid & tx_ready;

  assign w_rx_pop  = ~w_req.wr & (w_sel == SEL_DATA) & ~w_rx_empty;
  assign w_rx_push = rx_valid & rx_ready;

  always_comb begin
    w_rdata   = 8'h00;
    w_snap_ld = 1'b0;
    unique case (w_sel)
      SEL_RAM: w_rdata = r_ram[w_idx];
      SEL_DATA: begin
        if (!w_rx_empty)
          w_rdata = w_rx_dout;
      end
      SEL_STAT: begin
        // Lane 0 reads live and latches the snapshot the upper
        // lanes read, so a dword read is coherent.
        unique case (w_req.a[1:0])
          2'd0: begin
            w_rdata   = r_cnt[7:0];
            w_snap_ld = ~w_req.wr;
          end
          2'd1: w_rdata = r_snap[15:8];
          2'd2: w_rdata = r_snap[23:16];
          default: w_rdata = r_snap[31:24];
        endcase
      end
      default: w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_ram_wr)
      r_ram[w_idx] <= w_req.dout;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cpu_din <= 8'h00;
      r_cnt     <= '0;
      r_snap    <= '0;
      r_stop    <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (!w_req.wr)
        r_cpu_din <= w_rdata;
      if (w_snap_ld)
        r_snap <= r_cnt;
      if (w_stop_wr)
        r_stop <= 1'b1;
    end
  end

  byte_fifo #(
    .WIDTH(FIFO_WIDTH),
    .SIZE (FIFO_SIZE)
  ) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_push (w_rx_push),
    .i_din  (rx_data),
    .i_pop  (w_rx_pop),
    .o_dout (w_rx_dout),
    .o_full (w_rx_full),
    .o_empty(w_rx_empty),
    .o_count(w_rx_count)
  );

  byte_fifo #(
    .WIDTH(FIFO_WIDTH),
    .SIZE (FIFO_SIZE)
  ) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .i_push (w_tx_push),
    .i_din  (w_tx_din),
    .i_pop  (w_tx_pop),
    .o_dout (tx_data),
    .o_full (w_tx_full),
    .o_empty(w_tx_empty),
    .o_count(w_tx_count)
  );

  // Two slots of margin: a CPU write may already be in flight
  // when the flag rises.
  assign io_buffer_full =
    (w_tx_count >= (FIFO_WIDTH+1)'(FIFO_SIZE - 2));

  assign cpu_din   = r_cpu_din;
  assign rx_ready  = ~w_rx_full;
  assign tx_valid  = ~w_tx_empty;
  assign prog_stop = r_stop;

  assign w_unused = ^{cpu_a[31:18], w_rx_count, w_tx_full};

endmodule
